// File: rtl/txuart_outbox.sv
// Buffered UART transmitter: bytes queue in a circular FIFO and leave as 8N1 frames on o_uart_tx.
// Optional macro TXUART_PARITY_EN adds an even-parity bit between the data and stop bits.
module txuart_outbox #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104,
  parameter logic [3:0]  LGFLEN          = 4'd4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_wr,
  input  logic [7:0]      i_data,
  output logic            o_full,
  output logic            o_empty_n,
  output logic [LGFLEN:0] o_fill,
  output logic            o_overflow,
  output logic            o_busy,
  output logic            o_uart_tx
);

  localparam int LG    = int'(LGFLEN);
  localparam int DEPTH = 1 << LG;
  localparam int CW    = $clog2(int'(CLOCKS_PER_BAUD));

  typedef logic [LG-1:0] ptr_t;
  typedef logic [LG:0]   fill_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t  BAUD_LAST = cnt_t'(CLOCKS_PER_BAUD - 24'd1);
  localparam fill_t FILL_FULL = fill_t'(DEPTH);

`ifdef TXUART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  logic [1:0] rst_sync;
  logic       rst_n;

  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  fill_t      fill;
  fill_t      fill_next;
  logic       push;
  logic       pop;
  logic [7:0] head;

  state_t     state;
  state_t     state_next;
  cnt_t       cnt;
  cnt_t       cnt_next;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_next;
  logic [7:0] shift;
  logic [7:0] shift_next;
  logic       tx_next;
  logic       bit_end;
`ifdef TXUART_PARITY_EN
  logic       par;
  logic       par_next;
`endif

  // Reset synchronizer: assertion is immediate, release is aligned to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_n = rst_sync[1];

  // Writes are gated by the registered full flag, so a dropped byte never touches storage.
  assign push    = i_wr && !o_full;
  assign head    = mem[rd_ptr];
  assign o_fill  = fill;
  assign bit_end = (cnt == cnt_t'(0));

  // FIFO storage; no reset needed since occupancy tracking guards every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Next occupancy from push/pop of this cycle.
  always_comb begin
    fill_next = fill;
    case ({push, pop})
      2'b10:   fill_next = fill + fill_t'(1);
      2'b01:   fill_next = fill - fill_t'(1);
      default: fill_next = fill;
    endcase
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= ptr_t'(0);
      rd_ptr     <= ptr_t'(0);
      fill       <= fill_t'(0);
      o_full     <= 1'b0;
      o_empty_n  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      fill       <= fill_next;
      o_full     <= (fill_next == FILL_FULL);
      o_empty_n  <= (fill_next != fill_t'(0));
      o_overflow <= i_wr && o_full;
    end
  end

  // Frame sequencer: next state, bit counter, shifter and line level.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    tx_next      = o_uart_tx;
    pop          = 1'b0;
`ifdef TXUART_PARITY_EN
    par_next     = par;
`endif
    case (state)
      IDLE: begin
        if (o_empty_n) begin
          pop        = 1'b1;
          shift_next = head;
`ifdef TXUART_PARITY_EN
          par_next   = even_parity(head);
`endif
          tx_next    = 1'b0;
          cnt_next   = BAUD_LAST;
          state_next = START;
        end else begin
          tx_next = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = shift[0];
          cnt_next     = BAUD_LAST;
        end else begin
          cnt_next = cnt - cnt_t'(1);
        end
      end
      DATA: begin
        if (!bit_end) begin
          cnt_next = cnt - cnt_t'(1);
        end else if (bit_idx == 3'd7) begin
          cnt_next   = BAUD_LAST;
`ifdef TXUART_PARITY_EN
          state_next = PARITY;
          tx_next    = par;
`else
          state_next = STOP;
          tx_next    = 1'b1;
`endif
        end else begin
          bit_idx_next = bit_idx + 3'd1;
          shift_next   = {1'b0, shift[7:1]};
          tx_next      = shift[1];
          cnt_next     = BAUD_LAST;
        end
      end
`ifdef TXUART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
          cnt_next   = BAUD_LAST;
        end else begin
          cnt_next = cnt - cnt_t'(1);
        end
      end
`endif
      STOP: begin
        if (!bit_end) begin
          cnt_next = cnt - cnt_t'(1);
        end else if (o_empty_n) begin
          // Chain straight into the next start bit so queued frames stay contiguous.
          pop        = 1'b1;
          shift_next = head;
`ifdef TXUART_PARITY_EN
          par_next   = even_parity(head);
`endif
          tx_next    = 1'b0;
          cnt_next   = BAUD_LAST;
          state_next = START;
        end else begin
          tx_next    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Sequencer registers; the line and busy flag come straight from flops.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= cnt_t'(0);
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      o_uart_tx <= 1'b1;
      o_busy    <= 1'b0;
`ifdef TXUART_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      o_uart_tx <= tx_next;
      o_busy    <= (state_next != IDLE);
`ifdef TXUART_PARITY_EN
      par       <= par_next;
`endif
    end
  end

endmodule

// File: tb/tb_txuart_outbox.sv
// Randomized self-checking bench for txuart_outbox against a frame-level reference model.
// The model follows TXUART_PARITY_EN the same way the design does.
module tb_txuart_outbox;

  localparam int CPB   = 104;
  localparam int DEPTH = 16;
`ifdef TXUART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_wr;
  logic [7:0] i_data;
  logic       o_full;
  logic       o_empty_n;
  logic [4:0] o_fill;
  logic       o_overflow;
  logic       o_busy;
  logic       o_uart_tx;

  txuart_outbox #(
    .CLOCKS_PER_BAUD(24'd104),
    .LGFLEN(4'd4)
  ) dut (
    .i_clk(clk),
    .i_rst_n(i_rst_n),
    .i_wr(i_wr),
    .i_data(i_data),
    .o_full(o_full),
    .o_empty_n(o_empty_n),
    .o_fill(o_fill),
    .o_overflow(o_overflow),
    .o_busy(o_busy),
    .o_uart_tx(o_uart_tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model state
  int         m_fill = 0;
  logic [7:0] m_q[$];
  int         cur_start = -1;
  int         busy_until = 0;
  logic [7:0] cur_byte = 8'h00;
  int         frame_err = 0;
  int         frame_no = 0;
  int         idle_err = 0;
  int         stat_err = 0;

  // Line level of bit i of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef TXUART_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Advance one clock, update the model and compare every output at the negedge.
  task automatic tick();
    logic       wr_now;
    logic [7:0] d_now;
    int         fb;
    logic       acc;
    logic       pop;
    logic       exp_ovf;
    logic       in_frame;
    logic       exp_tx;
    wr_now  = i_wr;
    d_now   = i_data;
    exp_ovf = 1'b0;
    @(negedge clk);
    cyc++;
    if (!i_rst_n) begin
      m_fill     = 0;
      m_q.delete();
      cur_start  = -1;
      busy_until = 0;
    end else begin
      fb  = m_fill;
      pop = (fb > 0) && (cyc >= busy_until);
      acc = wr_now && (fb < DEPTH);
      if (pop) begin
        cur_byte   = m_q.pop_front();
        cur_start  = cyc;
        busy_until = cyc + FRAME;
        frame_err  = 0;
      end
      if (acc) m_q.push_back(d_now);
      m_fill  = fb + (acc ? 1 : 0) - (pop ? 1 : 0);
      exp_ovf = wr_now && (fb == DEPTH);
    end
    in_frame = (cur_start >= 0) && (cyc < busy_until);
    if (in_frame) begin
      exp_tx = frame_bit(cur_byte, (cyc - cur_start) / CPB);
      if (o_uart_tx !== exp_tx || o_busy !== 1'b1) frame_err++;
      if (cyc == busy_until - 1) begin
        total++;
        if (frame_err != 0) begin
          bad++;
          $display("FAIL frame_%0d byte=%02h: cycles off reference=%0d want 0", frame_no, cur_byte, frame_err);
        end
        frame_no++;
      end
    end else if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) begin
      idle_err++;
    end
    if (o_fill !== m_fill[4:0] || o_full !== (m_fill == DEPTH) ||
        o_empty_n !== (m_fill != 0) || o_overflow !== exp_ovf) begin
      stat_err++;
      if (stat_err == 1)
        $display("FAIL status at cycle %0d: fill=%0d full=%b empty_n=%b ovf=%b want fill=%0d ovf=%b",
                 cyc, o_fill, o_full, o_empty_n, o_overflow, m_fill, exp_ovf);
    end
  endtask

  task automatic end_window(input string name);
    total++;
    if (idle_err != 0) begin
      bad++;
      $display("FAIL %s_idle_line: bad idle cycles=%0d want 0", name, idle_err);
    end
    total++;
    if (stat_err != 0) begin
      bad++;
      $display("FAIL %s_status: bad status cycles=%0d want 0", name, stat_err);
    end
    idle_err = 0;
    stat_err = 0;
  endtask

  task automatic write_seq(input logic [7:0] bytes[$], output int e0);
    e0 = cyc + 1;
    foreach (bytes[i]) begin
      i_wr   = 1'b1;
      i_data = bytes[i];
      tick();
    end
    i_wr   = 1'b0;
    i_data = 8'($urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((o_busy || o_empty_n) && n < budget) begin
      tick();
      n++;
    end
    tick();
    tick();
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles want idle", name, budget);
    end
  endtask

  task automatic busy_fall(input int budget, output int fall);
    logic seen;
    seen = 1'b0;
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_busy) seen = 1'b1;
      else if (seen) begin
        fall = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) tick();
    total += 6;
    if (o_uart_tx !== 1'b1)  begin bad++; $display("FAIL reset_tx: got %b want 1", o_uart_tx); end
    if (o_busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    if (o_full !== 1'b0)     begin bad++; $display("FAIL reset_full: got %b want 0", o_full); end
    if (o_empty_n !== 1'b0)  begin bad++; $display("FAIL reset_empty_n: got %b want 0", o_empty_n); end
    if (o_fill !== 5'd0)     begin bad++; $display("FAIL reset_fill: got %0d want 0", o_fill); end
    if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
    i_rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_idle();
    repeat (2000) tick();
    end_window("idle");
  endtask

  task automatic test_single();
    logic [7:0] q[$];
    int e;
    int fall;
    q = {8'h55};
    write_seq(q, e);
    busy_fall(FRAME + 50, fall);
    total++;
    if (fall != e + 1 + FRAME) begin
      bad++;
      $display("FAIL single_busy_fall: got cycle %0d want %0d", fall, e + 1 + FRAME);
    end
    wait_idle("single", 200);
    end_window("single");
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int e;
    int fall;
    q = {8'hA5, 8'h3C};
    write_seq(q, e);
    busy_fall(2 * FRAME + 50, fall);
    total++;
    if (fall != e + 1 + 2 * FRAME) begin
      bad++;
      $display("FAIL b2b_busy_fall: got cycle %0d want %0d", fall, e + 1 + 2 * FRAME);
    end
    wait_idle("b2b", 200);
    end_window("b2b");
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 18; i++) begin
      i_wr   = 1'b1;
      i_data = 8'($urandom);
      tick();
      if (i == 16) begin
        total++;
        if (o_fill !== 5'd16 || o_full !== 1'b1) begin
          bad++;
          $display("FAIL full_after_17: fill=%0d full=%b want fill=16 full=1", o_fill, o_full);
        end
      end
      if (i == 17) begin
        total++;
        if (o_overflow !== 1'b1 || o_fill !== 5'd16) begin
          bad++;
          $display("FAIL overflow_pulse: ovf=%b fill=%0d want ovf=1 fill=16", o_overflow, o_fill);
        end
      end
    end
    i_wr = 1'b0;
    tick();
    total++;
    if (o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_width: ovf=%b want 0", o_overflow);
    end
    wait_idle("full", 20 * FRAME);
    end_window("full");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] q[$];
    int e;
    int target;
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    write_seq(q, e);
    target = e + 1 + 4 * CPB + CPB / 2;
    while (cyc < target) tick();
    total++;
    if (o_fill !== 5'd5) begin
      bad++;
      $display("FAIL midreset_queued: fill=%0d want 5", o_fill);
    end
    i_rst_n = 1'b0;
    #1;
    total += 3;
    if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL midreset_tx: got %b want 1", o_uart_tx); end
    if (o_busy !== 1'b0)    begin bad++; $display("FAIL midreset_busy: got %b want 0", o_busy); end
    if (o_fill !== 5'd0)    begin bad++; $display("FAIL midreset_fill: got %0d want 0", o_fill); end
    repeat (3) tick();
    i_rst_n = 1'b1;
    repeat (3000) tick();
    total++;
    if (o_fill !== 5'd0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_after: fill=%0d busy=%b want 0 0", o_fill, o_busy);
    end
    end_window("midreset");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        i_wr   = 1'b1;
        i_data = 8'($urandom);
        tick();
        i_wr   = 1'b0;
        i_data = 8'($urandom);
        repeat ($urandom_range(0, 3)) tick();
      end
      repeat ($urandom_range(0, 1500)) tick();
    end
    wait_idle("random", 6 * FRAME);
    end_window("random");
  endtask

`ifdef TXUART_PARITY_EN
  task automatic test_parity();
    logic [7:0] q[$];
    int e;
    int t1;
    int t2;
    q = {8'h07, 8'h03};
    write_seq(q, e);
    t1 = e + 1 + 9 * CPB + CPB / 2;
    t2 = t1 + FRAME;
    while (cyc < t1) tick();
    total++;
    if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL parity_07: got %b want 1", o_uart_tx); end
    while (cyc < t2) tick();
    total++;
    if (o_uart_tx !== 1'b0) begin bad++; $display("FAIL parity_03: got %b want 0", o_uart_tx); end
    wait_idle("parity", 3 * FRAME);
    end_window("parity");
  endtask
`endif

  initial begin
    i_rst_n = 1'b0;
    i_wr    = 1'b0;
    i_data  = 8'h00;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_full_overflow();
    test_reset_mid_frame();
    test_random();
`ifdef TXUART_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
